// File: rtl/unified_memory.sv
// Unified instruction+data RAM responder with programmable wait states and a MemReady pulse.
// Optional write protection below PROT_LIMIT is enabled by defining UNIFIED_MEM_PROTECT_EN.
module unified_memory #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2,
  parameter int PROT_LIMIT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemFault,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef UNIFIED_MEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state, nstate;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr, lat_both;

  logic              req, fire, prot;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              c_wr, c_both;

  assign req = MemRead | MemWrite;

  // With zero wait states the access completes on the acceptance edge, so the
  // completing operands come straight from the ports instead of the latches.
  always_comb begin
    nstate = state;
    fire   = 1'b0;
    c_addr = lat_addr;
    c_data = lat_data;
    c_wr   = lat_wr;
    c_both = lat_both;
    case (state)
      IDLE: begin
        if (req) begin
          c_addr = Addr;
          c_data = WriteData;
          c_wr   = MemWrite;
          c_both = MemRead & MemWrite;
          if (WAIT_STATES == 0) begin
            nstate = DONE;
            fire   = 1'b1;
          end else begin
            nstate = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          nstate = IDLE;
        end else if (cnt == 4'd1) begin
          nstate = DONE;
          fire   = 1'b1;
        end
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
    prot = PROT_EN && c_wr && (int'(c_addr) < PROT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ReadData <= '0;
      MemReady <= 1'b0;
      MemFault <= 1'b0;
      Busy     <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      lat_both <= 1'b0;
    end else begin
      state    <= nstate;
      Busy     <= (nstate != IDLE);
      MemReady <= fire;
      MemFault <= fire && (c_both || prot);
      if (state == IDLE && req) begin
        lat_addr <= Addr;
        lat_data <= WriteData;
        lat_wr   <= MemWrite;
        lat_both <= MemRead & MemWrite;
        cnt      <= 4'(WAIT_STATES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !c_wr) begin
        ReadData <= mem[c_addr];
      end
    end
  end

  // RAM has no reset; a reset in the completion cycle still suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && fire && c_wr && !prot) begin
      mem[c_addr] <= c_data;
    end
  end

endmodule

// File: tb/tb_unified_memory.sv
// Randomized self-checking bench for unified_memory: two instances (2 and 0 wait states)
// checked against an array-based reference model of the memory and its timing.
module tb_unified_memory;

`ifdef UNIFIED_MEM_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  localparam int PROT_LIMIT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [7:0]  Addr = '0;
  logic [15:0] WriteData = '0;
  logic [15:0] rdata0, rdata1, rdata_s;
  logic        ready0, ready1, fault0, fault1, busy0, busy1;
  logic        ready_s, fault_s, busy_s;
  int          sel = 0;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] mm  [2][256];
  bit          kn  [2][256];
  logic [15:0] rdv [2];
  bit          rdk [2];

  always #5 clk = ~clk;

  unified_memory #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(2), .PROT_LIMIT(PROT_LIMIT)) u0 (
    .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rdata0), .MemReady(ready0), .MemFault(fault0), .Busy(busy0)
  );

  unified_memory #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(0), .PROT_LIMIT(PROT_LIMIT)) u1 (
    .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rdata1), .MemReady(ready1), .MemFault(fault1), .Busy(busy1)
  );

  always_comb begin
    rdata_s = (sel == 1) ? rdata1 : rdata0;
    ready_s = (sel == 1) ? ready1 : ready0;
    fault_s = (sel == 1) ? fault1 : fault0;
    busy_s  = (sel == 1) ? busy1  : busy0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_req(input int d, input bit rd, input bit wr);
    rd0 = (d == 0) ? rd : 1'b0;
    wr0 = (d == 0) ? wr : 1'b0;
    rd1 = (d == 1) ? rd : 1'b0;
    wr1 = (d == 1) ? wr : 1'b0;
  endtask

  task automatic check_idle(input string tag, input int d);
    check({tag, ".ready"}, ready_s, 1'b0);
    check({tag, ".busy"},  busy_s,  1'b0);
    check({tag, ".fault"}, fault_s, 1'b0);
    if (rdk[d]) check({tag, ".rdata"}, rdata_s, rdv[d]);
  endtask

  // stop: 0 = run to completion, else cycle at which the request is dropped
  // (use_rst=0) or reset is asserted instead (use_rst=1).
  task automatic access(input int d, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [15:0] wd, input int stop, input bit use_rst);
    int lat;
    bit prot, fault;
    lat   = (d == 0) ? 3 : 1;
    prot  = PROT_EN && wr && (int'(a) < PROT_LIMIT);
    fault = (rd && wr) || prot;
    @(negedge clk);
    sel = d;
    Addr = a;
    WriteData = wd;
    drive_req(d, rd, wr);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check("ready", ready_s, (i == lat));
      check("busy", busy_s, 1'b1);
      if (i == lat) begin
        check("fault", fault_s, fault);
        if (wr && !prot) begin
          mm[d][a] = wd;
          kn[d][a] = 1'b1;
        end else if (rd && !wr) begin
          rdv[d] = mm[d][a];
          rdk[d] = kn[d][a];
        end
        if (rdk[d]) check("rdata", rdata_s, rdv[d]);
        drive_req(d, 1'b0, 1'b0);
        @(negedge clk);
        check_idle("post", d);
        return;
      end
      if (stop == i) begin
        drive_req(d, 1'b0, 1'b0);
        if (use_rst) begin
          reset = 1'b1;
          rdv[0] = '0; rdv[1] = '0;
          rdk[0] = 1'b1; rdk[1] = 1'b1;
        end
        @(negedge clk);
        check_idle(use_rst ? "reset_mid" : "abort", d);
        reset = 1'b0;
        return;
      end
      Addr = 8'($urandom);
      WriteData = 16'($urandom);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 256; j++) begin
        mm[d][j] = '0;
        kn[d][j] = 1'b0;
      end
      rdv[d] = '0;
      rdk[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_idle("rst0", 0);
    sel = 1;
    check_idle("rst1", 1);
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst1_rel", 1);

    // directed scenarios
    access(0, 0, 1, 8'h80, 16'hBEEF, 0, 0);
    access(0, 1, 0, 8'h80, 16'h0000, 0, 0);
    access(1, 0, 1, 8'h05, 16'h1234, 0, 0);
    access(1, 1, 0, 8'h05, 16'h0000, 0, 0);
    access(0, 0, 1, 8'h90, 16'h1111, 0, 0);
    access(0, 0, 1, 8'h90, 16'h00AA, 1, 0);
    access(0, 1, 0, 8'h90, 16'h0000, 0, 0);
    access(0, 0, 1, 8'h90, 16'h00BB, 2, 0);
    access(0, 1, 0, 8'h90, 16'h0000, 0, 0);
    access(0, 1, 1, 8'h91, 16'h5555, 0, 0);
    access(0, 1, 0, 8'h91, 16'h0000, 0, 0);
    access(0, 0, 1, 8'hA0, 16'h2222, 0, 0);
    access(0, 1, 0, 8'h80, 16'h0000, 0, 0);
    access(0, 0, 1, 8'hA0, 16'h7777, 1, 1);
    access(0, 1, 0, 8'hA0, 16'h0000, 0, 0);
    access(0, 0, 1, 8'h10, 16'h0AAA, 0, 0);
    access(0, 0, 1, 8'h10, 16'hFFFF, 0, 0);
    access(0, 1, 0, 8'h10, 16'h0000, 0, 0);
    access(1, 0, 1, 8'hFF, 16'hCAFE, 0, 0);
    access(1, 1, 1, 8'h20, 16'h4321, 0, 0);
    access(1, 1, 0, 8'hFF, 16'h0000, 0, 0);

    // randomized traffic over a small address window so reads hit written words
    for (int n = 0; n < 160; n++) begin
      int d, op, stop;
      logic [7:0] a;
      d  = n % 2;
      op = $urandom_range(0, 9);
      a  = (($urandom_range(0, 1) == 0) ? 8'h30 : 8'hC0) + 8'($urandom_range(0, 15));
      stop = 0;
      if (d == 0 && $urandom_range(0, 7) == 0) stop = $urandom_range(1, 2);
      if (op < 4)      access(d, 1, 0, a, 16'($urandom), stop, 0);
      else if (op < 9) access(d, 0, 1, a, 16'($urandom), stop, 0);
      else             access(d, 1, 1, a, 16'($urandom), stop, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
